// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port general-purpose register file with a built-in pending-write
// scoreboard. It has NUM_RD combinational read ports and two clocked write
// ports: port 0 is ALU writeback and port 1 is load writeback.
//
// Each register has a busy bit. Decode can use it to detect read-after-write
// hazards. Register 0 has no storage, reads as zero and is never busy.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   - rd_data forwards same-cycle write data (port 1 over port 0).
//   undefined - rd_data returns stored contents only.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       set_busy,
    input  logic [ADDR_W-1:0]          set_addr,
    input  logic                       flush
);

    localparam int NREG = 1 << ADDR_W;

    // Register 0 is hardwired to zero, so storage starts at index 1.
    logic [DATA_W-1:0] regs_r [1:NREG-1];
    logic [NREG-1:1]   busy_r;

    // Returns true when write port is enabled and targets register idx.
    function automatic logic wr_hit(input logic we, input logic [ADDR_W-1:0] wa,
                                    input logic [ADDR_W-1:0] idx);
        wr_hit = we && (wa == idx) && (idx != {ADDR_W{1'b0}});
    endfunction

    // Register data update: port 1 is checked first, so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_hit(we1, wa1, ADDR_W'(i))) begin
                    regs_r[i] <= wd1;
                end else if (wr_hit(we0, wa0, ADDR_W'(i))) begin
                    regs_r[i] <= wd0;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Busy scoreboard update. Flush has top priority, then a new claim, then a write clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= '0;
        end else if (flush) begin
            busy_r <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (set_busy && (set_addr == ADDR_W'(i))) begin
                    busy_r[i] <= 1'b1;
                end else if (wr_hit(we0, wa0, ADDR_W'(i)) || wr_hit(we1, wa1, ADDR_W'(i))) begin
                    busy_r[i] <= 1'b0;
                end else begin
                    busy_r[i] <= busy_r[i];
                end
            end
        end
    end

    // Combinational read ports. Address 0 falls through to zero because there is no storage entry for it.
    always_comb begin
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr_s = rd_addr[k*ADDR_W +: ADDR_W];
            data_s = {DATA_W{1'b0}};
            busy_s = 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (addr_s == ADDR_W'(i)) begin
                    data_s = regs_r[i];
                    busy_s = busy_r[i];
                end else begin
                    data_s = data_s;
                    busy_s = busy_s;
                end
            end
`ifdef REGFILE_BYPASS_EN
            // Forward in-flight write data. Reset suppresses forwarding so reads stay zero.
            if (!reset && wr_hit(we1, wa1, addr_s)) begin
                data_s = wd1;
            end else if (!reset && wr_hit(we0, wa0, addr_s)) begin
                data_s = wd0;
            end else begin
                data_s = data_s;
            end
`endif
            rd_data[k*DATA_W +: DATA_W] = data_s;
            rd_busy[k]                  = busy_s;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed, table-driven bench for regfile_mp with the default parameters
// (32-bit data, 5-bit address, 2 read ports).
//
// Each table vector drives writes, sets and flush for one edge. The bench then
// reads two addresses after that edge and compares them against hand-computed
// values. Hand-written sequences cover same-cycle bypass and asynchronous
// reset.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1, set_busy, flush;
    logic [4:0]  wa0, wa1, set_addr;
    logic [31:0] wd0, wd1;

    int total = 0;
    int fails = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1),
        .wa1(wa1), .wd1(wd1), .set_busy(set_busy), .set_addr(set_addr),
        .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we0; logic [4:0] wa0; logic [31:0] wd0;
        logic        we1; logic [4:0] wa1; logic [31:0] wd1;
        logic        sb;  logic [4:0] sa;  logic        fl;
        logic [4:0]  ra0; logic [4:0] ra1;
        logic [31:0] ed0; logic [31:0] ed1;
        logic        eb0; logic       eb1;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = 5'd0; wd0 = 32'd0;
        we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0;
        set_busy = 1'b0; set_addr = 5'd0; flush = 1'b0;
    endtask

    initial begin
        //        we0  wa0    wd0            we1  wa1    wd1            sb  sa     fl  ra0    ra1    ed0            ed1            eb0 eb1
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0,     1'b1, 5'd0,  1'b0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd7,  32'h00000011, 1'b1, 5'd7,  32'h22,    1'b0, 5'd0,  1'b0, 5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b1, 5'd9,  1'b0, 5'd9,  5'd7,  32'h0,        32'h22,       1'b1, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hAAAA,  1'b1, 5'd9,  1'b0, 5'd9,  5'd0,  32'hAAAA,     32'h0,        1'b1, 1'b0};
        vecs[5]  = '{1'b1, 5'd9,  32'hBBBB,     1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  1'b0, 5'd9,  5'd7,  32'hBBBB,     32'h22,       1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b1, 5'd3,  1'b0, 5'd3,  5'd9,  32'h0,        32'hBBBB,     1'b1, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b1, 5'd12, 1'b0, 5'd12, 5'd3,  32'h0,        32'h0,        1'b1, 1'b1};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b1, 5'd3,  1'b1, 5'd3,  5'd12, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd4,  32'h0000000A, 1'b1, 5'd12, 32'h55,    1'b1, 5'd12, 1'b0, 5'd4,  5'd12, 32'hA,        32'h55,       1'b0, 1'b1};
        vecs[10] = '{1'b1, 5'd20, 32'h00000001, 1'b1, 5'd31, 32'h2,     1'b0, 5'd0,  1'b0, 5'd20, 5'd31, 32'h1,        32'h2,        1'b0, 1'b0};

        idle_inputs();
        reset = 1'b1;
        rd_addr = 10'd0;

        // A write attempted during reset must be ignored.
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hFFFF_FFFF; set_busy = 1'b1; set_addr = 5'd5;
        @(posedge clk); #1;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            check($sformatf("reset data p0 a%0d", a), rd_data[31:0], 32'h0);
            check($sformatf("reset data p1 a%0d", 31 - a), rd_data[63:32], 32'h0);
            check($sformatf("reset busy a%0d", a), {30'd0, rd_busy}, 32'h0);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;

        // Table-driven vectors: drive for one edge, then read back after the edge.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
            we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
            set_busy = vecs[i].sb; set_addr = vecs[i].sa; flush = vecs[i].fl;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            @(posedge clk); #1;
            idle_inputs();
            #1;
            check($sformatf("vec%0d data0", i), rd_data[31:0], vecs[i].ed0);
            check($sformatf("vec%0d data1", i), rd_data[63:32], vecs[i].ed1);
            check($sformatf("vec%0d busy0", i), {31'd0, rd_busy[0]}, {31'd0, vecs[i].eb0});
            check($sformatf("vec%0d busy1", i), {31'd0, rd_busy[1]}, {31'd0, vecs[i].eb1});
        end

        // Same-cycle visibility: register 4 holds 0xA, so write 0xB while reading it.
        @(negedge clk);
        rd_addr = {5'd4, 5'd4};
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hB;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass pre-edge p0", rd_data[31:0], 32'hB);
        check("bypass pre-edge p1", rd_data[63:32], 32'hB);
`else
        check("nobypass pre-edge p0", rd_data[31:0], 32'hA);
        check("nobypass pre-edge p1", rd_data[63:32], 32'hA);
`endif
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check("write 4 post-edge", rd_data[31:0], 32'hB);

        // Both ports write the register being read. Port 1 must be forwarded and must win the write.
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hC;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hD;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass priority pre-edge", rd_data[31:0], 32'hD);
`else
        check("nobypass priority pre-edge", rd_data[31:0], 32'hB);
`endif
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check("collision post-edge", rd_data[31:0], 32'hD);

        // Asynchronous reset mid-cycle: register 12 is 0x55 and busy from vec9.
        @(negedge clk);
        rd_addr = {5'd4, 5'd12};
        #1;
        check("pre-reset data12", rd_data[31:0], 32'h55);
        check("pre-reset busy12", {31'd0, rd_busy[0]}, 32'h1);
        #1;
        reset = 1'b1;
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h99;
        #1;
        check("async reset data12", rd_data[31:0], 32'h0);
        check("async reset busy12", {31'd0, rd_busy[0]}, 32'h0);
        check("async reset data4", rd_data[63:32], 32'h0);
        @(posedge clk); #1;
        check("reset held write ignored", rd_data[31:0], 32'h0);

        // First edge after deassertion accepts a write.
        @(negedge clk);
        reset = 1'b0;
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h77;
        set_busy = 1'b1; set_addr = 5'd4;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check("post-reset write12", rd_data[31:0], 32'h77);
        check("post-reset busy4", {31'd0, rd_busy[1]}, 32'h1);
        check("post-reset data4", rd_data[63:32], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file with a built-in pending-write scoreboard, for the pipelined core's decode/writeback stages. It provides NUM_RD combinational read ports and two clocked write ports, one for ALU writeback and one for memory/load writeback. A per-register busy bit lets decode detect read-after-write hazards without a separate scoreboard block. Register 0 always reads as zero.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; NREG = 2^ADDR_W registers, index 0 hardwired zero.
- NUM_RD, 2: number of read ports, at least 1.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way as rd_addr.
- rd_busy  out  NUM_RD  1 = addressed register has a pending producer.
- we0  in  1  write enable, port 0 (ALU writeback).
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (load writeback).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- set_busy  in  1  mark register set_addr as pending, on the next edge.
- set_addr  in  ADDR_W  register being claimed by an issued instruction.
- flush  in  1  synchronous: clear every busy bit; register data is kept.

## Operation
- Storage holds registers 1..NREG-1, each DATA_W bits; there is no flop for register 0.
- Reads are combinational. rd_data[k] = 0 and rd_busy[k] = 0 when rd_addr[k] == 0.
- Write port n commits wdn to register wan on the rising edge when wen = 1 and wan != 0. A write to address 0 is silently dropped.
- Both ports write the same nonzero address in one cycle: port 1 wins. The register takes wd1.
- Busy bit update at each edge, highest priority first:
  1. flush: all bits 0.
  2. set_busy with set_addr != 0: that bit becomes 1. This applies even if a write clears the same address in the same cycle, because the new producer supersedes the old one.
  3. Each enabled write with a nonzero address clears its address's bit.
- flush together with set_busy: flush wins, and all bits end up 0.
- Writes to registers whose busy bit is 0 are legal and only update data.

## Timing
- Reset (asynchronous assert, any cycle, including mid-write): all registers become 0 and all busy bits become 0 immediately. While reset is high, rd_data = 0 and rd_busy = 0 for every address, and writes and sets are ignored.
- Deassertion is sampled at clk. The first write can take effect on the first rising edge where reset is low.
- Write latency: data written at edge N is visible on rd_data from just after edge N. Same-cycle visibility depends on the configuration macro below.
- Busy latency: set_busy at edge N gives rd_busy = 1 after N. A write at edge M > N gives rd_busy = 0 after M.
- rd_busy is purely registered state. It is never bypassed.

## Configuration
- REGFILE_BYPASS_EN defined:
  - rd_data[k] returns the write data of an enabled write port whose nonzero address equals rd_addr[k] in the same cycle. Port 1 has priority over port 0, matching write priority.
  - This gives zero-cycle writeback-to-decode forwarding.
- REGFILE_BYPASS_EN undefined:
  - rd_data[k] returns stored contents only. The written value appears the cycle after the edge.

## Test plan
- Reset then read all addresses -> rd_data = 0 and rd_busy = 0 on every port. Write wa0=5, wd0=0xDEADBEEF; next cycle rd_addr=5 -> 0xDEADBEEF.
- we0=1 and wa0=0 with wd0=0x1234 -> rd_addr=0 still returns 0; set_busy with set_addr=0 -> rd_busy stays 0.
- Same-cycle we0 and we1 to address 7, wd0=0x11 and wd1=0x22 -> register 7 reads 0x22.
- set_busy on 9 -> rd_busy=1. Then in one cycle we1 to 9 plus set_busy on 9 -> still 1. Then we0 to 9 alone -> 0. Separately, flush with set_busy on 3 -> all busy bits 0.
- With REGFILE_BYPASS_EN, register 4 = 0xA, write 0xB to 4 while reading 4 in the same cycle -> 0xB before the edge. Without the macro -> 0xA before the edge, 0xB after.
- Assert reset asynchronously mid-cycle with register 12 = 0x55 and busy -> immediately rd_data=0 and rd_busy=0 for address 12, without waiting for a clk edge.
